// File: rtl/csum_pkg.sv
// ---------------------------------------------------------------------------
// csum_pkg
// Shared types and constants for the nibble-serial one's-complement checksum
// sequencer (csum_nibble_seq) and its 4-bit adder slice (lca_4bit).
//   csum_state_t : sequencer FSM states
//   CSUM_W_DEF   : default checksum / word width in bits
//   NIB_W        : width of one adder slice (nibble)
// ---------------------------------------------------------------------------
package csum_pkg;

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    ADD  = 2'd1,
    FOLD = 2'd2,
    DONE = 2'd3
  } csum_state_t;

  localparam int CSUM_W_DEF = 16;
  localparam int NIB_W      = 4;

endpackage : csum_pkg

// File: rtl/lca_4bit.sv
// ---------------------------------------------------------------------------
// lca_4bit
// Purely combinational 4-bit lookahead-carry adder slice.
// Ports:
//   a, b  in  4  operands
//   cin   in  1  carry in
//   sum   out 4  a + b + cin (low 4 bits)
//   cout  out 1  carry out of bit 3
// ---------------------------------------------------------------------------
module lca_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic       c1;
  logic       c2;
  logic       c3;
  logic       c4;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is expanded directly from g/p/cin so no ripple path exists.
  assign c1 = g[0]
            | (p[0] & cin);
  assign c2 = g[1]
            | (p[1] & g[0])
            | (p[1] & p[0] & cin);
  assign c3 = g[2]
            | (p[2] & g[1])
            | (p[2] & p[1] & g[0])
            | (p[2] & p[1] & p[0] & cin);
  assign c4 = g[3]
            | (p[3] & g[2])
            | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum  = p ^ {c3, c2, c1, cin};
  assign cout = c4;

endmodule : lca_4bit

// File: rtl/csum_nibble_seq.sv
// ---------------------------------------------------------------------------
// csum_nibble_seq
// 16-bit (CSUM_W) one's-complement checksum computed by time-sharing a single
// lca_4bit slice across the nibbles of each input word. The carry register is
// kept between words so the end-around carry of one word enters nibble 0 of
// the next; a trailing carry after the last word is folded back with extra
// passes that add zero.
// Parameters:
//   CSUM_W  word / checksum width, multiple of 4
//   INVERT  1: m_csum = ~sum (transmit checksum), 0: m_csum = raw sum
// Ports:
//   sys_clk   in   1       clock, rising edge
//   sys_rst   in   1       synchronous active-high reset
//   s_tdata   in   CSUM_W  input word
//   s_tvalid  in   1       input word valid
//   s_tlast   in   1       last word of packet
//   s_tready  out  1       word accepted (high only while waiting)
//   m_csum    out  CSUM_W  checksum result, stable while m_valid
//   m_valid   out  1       result valid
//   m_ready   in   1       result consumer ready
//   busy      out  1       packet in progress or accumulator non-zero
// ---------------------------------------------------------------------------
module csum_nibble_seq
  import csum_pkg::*;
#(
  parameter int CSUM_W = CSUM_W_DEF,
  parameter bit INVERT = 1'b1
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [CSUM_W-1:0] s_tdata,
  input  logic              s_tvalid,
  input  logic              s_tlast,
  output logic              s_tready,
  output logic [CSUM_W-1:0] m_csum,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy
);

  localparam int NIB_N = CSUM_W / NIB_W;
  localparam int CNT_W = (NIB_N > 1) ? $clog2(NIB_N) : 1;

  // -------------------------------------------------------------------------
  // Nibble select / replace helpers
  // -------------------------------------------------------------------------
  function automatic logic [NIB_W-1:0] nib_get(input logic [CSUM_W-1:0] v,
                                               input int                 idx);
    return v[idx*NIB_W +: NIB_W];
  endfunction

  function automatic logic [CSUM_W-1:0] nib_put(input logic [CSUM_W-1:0] v,
                                                input int                 idx,
                                                input logic [NIB_W-1:0]   n);
    logic [CSUM_W-1:0] r;
    r = v;
    r[idx*NIB_W +: NIB_W] = n;
    return r;
  endfunction

  function automatic logic [CSUM_W-1:0] out_fmt(input logic [CSUM_W-1:0] v);
    return INVERT ? ~v : v;
  endfunction

  csum_state_t        state_q;
  logic [CSUM_W-1:0]  acc_q;
  logic               carry_q;
  logic [CNT_W-1:0]   nib_cnt_q;
  logic [1:0]         fold_cnt_q;
  logic               last_q;
  logic [CSUM_W-1:0]  word_q;

  logic [NIB_W-1:0]   lca_a;
  logic [NIB_W-1:0]   lca_b;
  logic [NIB_W-1:0]   lca_sum;
  logic               lca_cout;
  logic [CSUM_W-1:0]  acc_nxt;
  logic               nib_last;

  // -------------------------------------------------------------------------
  // Datapath: nibble mux -> shared adder slice -> nibble demux
  // -------------------------------------------------------------------------
  always_comb begin
    lca_a = nib_get(acc_q, int'(nib_cnt_q));
    lca_b = '0;
    if (state_q == ADD) begin
      lca_b = nib_get(word_q, int'(nib_cnt_q));
    end
  end

  lca_4bit u_lca (
    .a    (lca_a),
    .b    (lca_b),
    .cin  (carry_q),
    .sum  (lca_sum),
    .cout (lca_cout)
  );

  assign acc_nxt  = nib_put(acc_q, int'(nib_cnt_q), lca_sum);
  assign nib_last = (nib_cnt_q == CNT_W'(NIB_N - 1));

  // Word holding register is pure data and needs no reset.
  always_ff @(posedge sys_clk) begin
    if (state_q == WAIT && s_tvalid && s_tready) begin
      word_q <= s_tdata;
    end
  end

  // -------------------------------------------------------------------------
  // Sequencer FSM with registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= WAIT;
      acc_q      <= '0;
      carry_q    <= 1'b0;
      nib_cnt_q  <= '0;
      fold_cnt_q <= '0;
      last_q     <= 1'b0;
      m_valid    <= 1'b0;
      m_csum     <= '0;
      s_tready   <= 1'b0;
    end else begin
      case (state_q)
        WAIT: begin
          // s_tready is a register, so it comes up one cycle after reset.
          if (!s_tready) begin
            s_tready <= 1'b1;
          end else if (s_tvalid) begin
            // carry_q deliberately kept: end-around carry of previous word.
            last_q    <= s_tlast;
            nib_cnt_q <= '0;
            s_tready  <= 1'b0;
            state_q   <= ADD;
          end
        end

        ADD, FOLD: begin
          acc_q   <= acc_nxt;
          carry_q <= lca_cout;
          if (!nib_last) begin
            nib_cnt_q <= nib_cnt_q + CNT_W'(1);
          end else begin
            nib_cnt_q <= '0;
            if (state_q == ADD && !last_q) begin
              s_tready <= 1'b1;
              state_q  <= WAIT;
            end else if (lca_cout) begin
              // Two fold passes always suffice; a third means a broken adder.
              if (state_q == FOLD) begin
                assert (fold_cnt_q < 2'd2);
                fold_cnt_q <= fold_cnt_q + 2'd1;
              end else begin
                fold_cnt_q <= 2'd1;
              end
              state_q <= FOLD;
            end else begin
              m_csum  <= out_fmt(acc_nxt);
              m_valid <= 1'b1;
              state_q <= DONE;
            end
          end
        end

        DONE: begin
          if (m_ready) begin
            acc_q    <= '0;
            carry_q  <= 1'b0;
            m_valid  <= 1'b0;
            s_tready <= 1'b1;
            state_q  <= WAIT;
          end
        end

        default: begin
          state_q <= WAIT;
        end
      endcase
    end
  end

  assign busy = (state_q != WAIT) || (acc_q != '0) || carry_q;

endmodule : csum_nibble_seq

// File: tb/tb_csum_nibble_seq.sv
// ---------------------------------------------------------------------------
// tb_csum_nibble_seq
// Self-checking bench for csum_nibble_seq (CSUM_W=16, INVERT=1). Expected
// checksums come from a 32-bit accumulate-and-fold model; expected latency
// comes from a word-level end-around-carry model counting fold passes.
// ---------------------------------------------------------------------------
module tb_csum_nibble_seq;

  localparam int W     = 16;
  localparam int NIB_N = W / 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] s_tdata;
  logic         s_tvalid;
  logic         s_tlast;
  logic         s_tready;
  logic [W-1:0] m_csum;
  logic         m_valid;
  logic         m_ready;
  logic         busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int hs_cyc = 0;

  csum_nibble_seq #(.CSUM_W(W), .INVERT(1'b1)) dut (
    .sys_clk  (clk),
    .sys_rst  (rst),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tlast  (s_tlast),
    .s_tready (s_tready),
    .m_csum   (m_csum),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: standard Internet checksum via wide sum then fold.
  function automatic logic [15:0] model_csum(input logic [15:0] w[$]);
    logic [31:0] s;
    s = 32'h0;
    foreach (w[i]) s = s + {16'h0, w[i]};
    while (s[31:16] != 16'h0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    return ~s[15:0];
  endfunction

  // Number of fold passes: carry-out of the final word-level add, re-added
  // until no carry remains.
  function automatic int model_folds(input logic [15:0] w[$]);
    logic [16:0] s;
    logic [15:0] a;
    logic        c;
    int          f;
    a = 16'h0;
    c = 1'b0;
    f = 0;
    foreach (w[i]) begin
      s = {1'b0, a} + {1'b0, w[i]} + {16'h0, c};
      a = s[15:0];
      c = s[16];
    end
    while (c) begin
      s = {1'b0, a} + {16'h0, c};
      a = s[15:0];
      c = s[16];
      f++;
    end
    return f;
  endfunction

  // Present one word after 'gap' idle cycles and wait for its handshake.
  // Called and returns at 1 time unit after a rising edge.
  task automatic send_word(input logic [15:0] w, input logic last, input int gap);
    int n;
    s_tvalid = 1'b0;
    for (int i = 0; i < gap; i++) begin
      @(posedge clk); #1;
    end
    s_tdata  = w;
    s_tlast  = last;
    s_tvalid = 1'b1;
    n = 0;
    while (!s_tready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!s_tready) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout s_tready=%b required 1", s_tready);
    end
    @(posedge clk); #1;
    hs_cyc   = cyc;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = $urandom();
  endtask

  task automatic wait_result(output logic [15:0] cs, output int lat, output bit ok);
    int n;
    n = 0;
    while (!m_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    ok  = m_valid;
    lat = cyc - hs_cyc;
    cs  = m_csum;
  endtask

  task automatic drive_packet(input logic [15:0] w[$], input int maxgap,
                              output logic [15:0] cs, output int lat, output bit ok);
    foreach (w[i]) send_word(w[i], (i == w.size() - 1), $urandom_range(0, maxgap));
    wait_result(cs, lat, ok);
  endtask

  task automatic release_result();
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
    checks++; if (m_csum !== 16'h0) begin errors++; $display("FAIL reset_m_csum got=%h exp=0000", m_csum); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL reset_s_tready got=%b exp=0", s_tready); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL post_reset_s_tready got=%b exp=1", s_tready); end
  endtask

  task automatic test_basic();
    logic [15:0] cs;
    int lat;
    bit ok;
    send_word(16'h0001, 1'b0, 0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b exp=1", busy); end
    send_word(16'h0002, 1'b1, 0);
    wait_result(cs, lat, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout m_valid=%b exp=1", m_valid); end
    checks++; if (cs !== 16'hFFFC) begin errors++; $display("FAIL basic_csum got=%h exp=FFFC", cs); end
    checks++; if (lat != NIB_N) begin errors++; $display("FAIL basic_latency got=%0d exp=%0d", lat, NIB_N); end
    release_result();
  endtask

  task automatic test_end_around();
    logic [15:0] w[$];
    logic [15:0] cs;
    int lat;
    bit ok;
    w = '{16'hFFFF, 16'h0001};
    drive_packet(w, 0, cs, lat, ok);
    checks++; if (!ok) begin errors++; $display("FAIL eac_timeout m_valid=%b exp=1", m_valid); end
    checks++; if (cs !== 16'hFFFE) begin errors++; $display("FAIL eac_csum got=%h exp=FFFE", cs); end
    checks++; if (lat != 2 * NIB_N) begin errors++; $display("FAIL eac_latency got=%0d exp=%0d", lat, 2 * NIB_N); end
    release_result();
  endtask

  task automatic test_double_fold();
    logic [15:0] w[$];
    logic [15:0] cs;
    int lat;
    bit ok;
    w = '{16'hFFFF, 16'hFFFF, 16'hFFFF};
    drive_packet(w, 0, cs, lat, ok);
    checks++; if (cs !== 16'h0000) begin errors++; $display("FAIL dfold_csum got=%h exp=0000", cs); end
    checks++; if (!ok || lat > 3 * NIB_N) begin errors++; $display("FAIL dfold_pass_bound latency=%0d exp<=%0d", lat, 3 * NIB_N); end
    checks++; if (lat != NIB_N * (1 + model_folds(w))) begin errors++; $display("FAIL dfold_latency got=%0d exp=%0d", lat, NIB_N * (1 + model_folds(w))); end
    release_result();
  endtask

  task automatic test_ip_header();
    logic [15:0] w[$];
    logic [15:0] cs;
    int lat;
    bit ok;
    w = '{16'h4500, 16'h0073, 16'h0000, 16'h4000, 16'h4011,
          16'h0000, 16'hc0a8, 16'h0001, 16'hc0a8, 16'h00c7};
    drive_packet(w, 0, cs, lat, ok);
    checks++; if (cs !== 16'hB861) begin errors++; $display("FAIL ip_csum got=%h exp=B861", cs); end
    release_result();
    drive_packet(w, 6, cs, lat, ok);
    checks++; if (cs !== 16'hB861) begin errors++; $display("FAIL ip_gaps_csum got=%h exp=B861", cs); end
    checks++; if (lat != NIB_N * (1 + model_folds(w))) begin errors++; $display("FAIL ip_gaps_latency got=%0d exp=%0d", lat, NIB_N * (1 + model_folds(w))); end
    release_result();
  endtask

  task automatic test_backpressure();
    logic [15:0] w[$];
    logic [15:0] cs;
    logic [15:0] held;
    int lat;
    bit ok;
    w = '{16'h8001, 16'h9002, 16'h7fff};
    drive_packet(w, 2, cs, lat, ok);
    held = model_csum(w);
    checks++; if (cs !== held) begin errors++; $display("FAIL bp_csum got=%h exp=%h", cs, held); end
    for (int i = 0; i < 10; i++) begin
      // Upstream offers a word it must not be able to hand over.
      s_tvalid = 1'b1;
      s_tdata  = 16'h5555;
      s_tlast  = 1'b1;
      @(posedge clk); #1;
      checks++; if (m_valid !== 1'b1 || m_csum !== held || s_tready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle=%0d m_valid=%b m_csum=%h s_tready=%b exp 1/%h/0", i, m_valid, m_csum, s_tready, held);
      end
    end
    s_tvalid = 1'b0;
    release_result();
    checks++; if (m_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_release m_valid=%b busy=%b exp 0/0", m_valid, busy); end
    w = '{16'h1234};
    drive_packet(w, 0, cs, lat, ok);
    checks++; if (cs !== 16'hEDCB) begin errors++; $display("FAIL bp_next_csum got=%h exp=EDCB", cs); end
    release_result();
  endtask

  task automatic test_reset_mid();
    logic [15:0] w[$];
    logic [15:0] cs;
    int lat;
    bit ok;
    send_word(16'h1111, 1'b0, 0);
    send_word(16'hABCD, 1'b1, 0);
    // Now in ADD with nib_cnt=0; two edges later nib_cnt=2.
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (m_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_state m_valid=%b busy=%b exp 0/0", m_valid, busy); end
    repeat (12) begin
      @(posedge clk); #1;
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rstmid_no_result m_valid=%b exp=0", m_valid); end
    end
    w = '{16'h00FF};
    drive_packet(w, 0, cs, lat, ok);
    checks++; if (cs !== 16'hFF00) begin errors++; $display("FAIL rstmid_next_csum got=%h exp=FF00", cs); end
    release_result();
  endtask

  task automatic test_random();
    logic [15:0] w[$];
    logic [15:0] cs;
    logic [15:0] exp_cs;
    int lat;
    int exp_lat;
    bit ok;
    for (int p = 0; p < 30; p++) begin
      w.delete();
      for (int i = 0; i < int'($urandom_range(1, 8)); i++) begin
        // Bias towards large words so carries and folds are exercised.
        w.push_back(($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom()));
      end
      exp_cs  = model_csum(w);
      exp_lat = NIB_N * (1 + model_folds(w));
      drive_packet(w, 3, cs, lat, ok);
      checks++; if (!ok || cs !== exp_cs) begin errors++; $display("FAIL rand_csum pkt=%0d got=%h exp=%h", p, cs, exp_cs); end
      checks++; if (lat != exp_lat) begin errors++; $display("FAIL rand_latency pkt=%0d got=%0d exp=%0d", p, lat, exp_lat); end
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 4)) begin
          @(posedge clk); #1;
        end
      end
      release_result();
    end
  endtask

  initial begin
    rst      = 1'b1;
    s_tdata  = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_ready  = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_end_around();
    test_double_fold();
    test_ip_header();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_csum_nibble_seq
